// File: rtl/main_memory_arbiter_if.sv
// Requester (I-side, D-side) and memory-port signals of main_memory_arbiter.
// The arbiter connects through the slave modport; the requesters and memory see the master side.
interface main_memory_arbiter_if;
   logic        ic_req;
   logic [31:0] ic_addr;
   logic        ic_ack;
   logic        ic_rvalid;
   logic [31:0] ic_rdata;
   logic        ic_done;

   logic        dc_req;
   logic        dc_rd_wr;
   logic        dc_burst;
   logic [1:0]  dc_wr_size;
   logic [31:0] dc_addr;
   logic [31:0] dc_wdata;
   logic        dc_ack;
   logic        dc_rvalid;
   logic [31:0] dc_rdata;
   logic        dc_done;

   logic        mem_en;
   logic        mem_rd_wr;
   logic [1:0]  mem_wr_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wdata_oe;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport slave (
      input  ic_req, ic_addr,
      input  dc_req, dc_rd_wr, dc_burst, dc_wr_size, dc_addr, dc_wdata,
      input  mem_rdata, mem_ready,
      output ic_ack, ic_rvalid, ic_rdata, ic_done,
      output dc_ack, dc_rvalid, dc_rdata, dc_done,
      output mem_en, mem_rd_wr, mem_wr_size, mem_addr, mem_wdata, mem_wdata_oe
   );

   modport master (
      output ic_req, ic_addr,
      output dc_req, dc_rd_wr, dc_burst, dc_wr_size, dc_addr, dc_wdata,
      output mem_rdata, mem_ready,
      input  ic_ack, ic_rvalid, ic_rdata, ic_done,
      input  dc_ack, dc_rvalid, dc_rdata, dc_done,
      input  mem_en, mem_rd_wr, mem_wr_size, mem_addr, mem_wdata, mem_wdata_oe
   );
endinterface

// File: rtl/main_memory_arbiter.sv
// Round-robin arbiter and access sequencer sharing one memory port between the I-cache fill
// path and the D-cache path; line fills run critical-word-first, wrapping inside the line.
module main_memory_arbiter #(
   parameter int LINE_WORDS = 4
) (
   input logic                  clk,
   input logic                  reset,
   main_memory_arbiter_if.slave bus
);
   localparam int              IDX_W      = $clog2(LINE_WORDS);
   localparam logic [IDX_W:0]  LINE_BEATS = LINE_WORDS[IDX_W:0];
   localparam logic [IDX_W:0]  ONE_BEAT   = {{IDX_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, ACCESS, GAP, DONE} state_t;
   typedef enum logic       {OWN_IC, OWN_DC} owner_t;

   state_t         state;
   owner_t         owner;
   owner_t         last_grant;
   logic [IDX_W:0] beat;
   logic [IDX_W:0] nbeats;

   logic           grant_ic;
   logic           grant_dc;
   logic           dc_line;
   logic           beat_last;
   logic           sel_rd_wr;
   logic [1:0]     sel_size;
   logic [31:0]    sel_addr;
   logic [31:0]    sel_wdata;
   logic [IDX_W:0] sel_beats;
   logic [31:0]    next_addr;

   // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
   always_comb begin
      grant_dc  = bus.dc_req && (!bus.ic_req || last_grant == OWN_IC);
      grant_ic  = bus.ic_req && !grant_dc;
      dc_line   = !bus.dc_rd_wr && bus.dc_burst;

      sel_rd_wr = 1'b0;
      sel_size  = 2'd0;
      sel_addr  = {bus.ic_addr[31:2], 2'b00};
      sel_wdata = '0;
      sel_beats = LINE_BEATS;
      if (grant_dc) begin
         sel_rd_wr = bus.dc_rd_wr;
         sel_size  = dc_line ? 2'd0 : bus.dc_wr_size;
         sel_addr  = dc_line ? {bus.dc_addr[31:2], 2'b00} : bus.dc_addr;
         sel_wdata = bus.dc_wdata;
         sel_beats = dc_line ? LINE_BEATS : ONE_BEAT;
      end

      // Advance only the word index; upper bits stay put so the burst wraps inside the line.
      next_addr                = bus.mem_addr;
      next_addr[IDX_W+1:2]     = bus.mem_addr[IDX_W+1:2] + ONE_BEAT[IDX_W-1:0];
      beat_last                = (beat + ONE_BEAT) == nbeats;
   end

   // Gated by reset so no ack escapes while the block is held in reset.
   assign bus.ic_ack = !reset && (state == IDLE) && grant_ic;
   assign bus.dc_ack = !reset && (state == IDLE) && grant_dc;

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         owner            <= OWN_IC;
         last_grant       <= OWN_IC;
         beat             <= '0;
         nbeats           <= '0;
         bus.mem_en       <= 1'b0;
         bus.mem_rd_wr    <= 1'b0;
         bus.mem_wr_size  <= 2'd0;
         bus.mem_addr     <= '0;
         bus.mem_wdata    <= '0;
         bus.mem_wdata_oe <= 1'b0;
         bus.ic_rvalid    <= 1'b0;
         bus.ic_rdata     <= '0;
         bus.ic_done      <= 1'b0;
         bus.dc_rvalid    <= 1'b0;
         bus.dc_rdata     <= '0;
         bus.dc_done      <= 1'b0;
      end else begin
         bus.ic_rvalid <= 1'b0;
         bus.dc_rvalid <= 1'b0;
         bus.ic_done   <= 1'b0;
         bus.dc_done   <= 1'b0;

         unique case (state)
            IDLE: begin
               if (grant_ic || grant_dc) begin
                  owner            <= grant_dc ? OWN_DC : OWN_IC;
                  bus.mem_rd_wr    <= sel_rd_wr;
                  bus.mem_wr_size  <= sel_size;
                  bus.mem_addr     <= sel_addr;
                  bus.mem_wdata    <= sel_wdata;
                  bus.mem_wdata_oe <= sel_rd_wr;
                  nbeats           <= sel_beats;
                  beat             <= '0;
                  bus.mem_en       <= 1'b1;
                  state            <= ACCESS;
               end
            end
            ACCESS: begin
               if (bus.mem_ready) begin
                  bus.mem_en       <= 1'b0;
                  bus.mem_wdata_oe <= 1'b0;
                  beat             <= beat + ONE_BEAT;
                  if (owner == OWN_IC) begin
                     bus.ic_rdata  <= bus.mem_rdata;
                     bus.ic_rvalid <= !bus.mem_rd_wr;
                     bus.ic_done   <= beat_last;
                  end else begin
                     bus.dc_rdata  <= bus.mem_rdata;
                     bus.dc_rvalid <= !bus.mem_rd_wr;
                     bus.dc_done   <= beat_last;
                  end
                  if (beat_last) begin
                     state <= DONE;
                  end else begin
                     bus.mem_addr <= next_addr;
                     state        <= GAP;
                  end
               end
            end
            GAP: begin
               bus.mem_en <= 1'b1;
               state      <= ACCESS;
            end
            DONE: begin
               last_grant <= owner;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_main_memory_arbiter.sv
// Self-checking bench for main_memory_arbiter: vector table plus hand-written corner sequences,
// with a memory responder and a scoreboard of expected accesses, returned words and completions.
module tb_main_memory_arbiter;
   localparam int LW = 4;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   main_memory_arbiter_if bus ();

   main_memory_arbiter #(.LINE_WORDS(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      bit          is_ic;
      bit          rd_wr;
      bit          burst;
      logic [1:0]  wr_size;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      int          exp_beats;
      logic [31:0] exp_addr0;
      logic [1:0]  exp_size;
   } vec_t;

   typedef struct packed {
      logic [31:0] addr;
      logic        rd_wr;
      logic [1:0]  size;
      logic [31:0] wdata;
   } acc_t;

   typedef struct packed {
      logic        is_ic;
      logic [31:0] data;
   } rv_t;

   typedef struct packed {
      logic is_ic;
      logic rv;
   } dn_t;

   acc_t acc_q[$];
   rv_t  rv_q[$];
   dn_t  dn_q[$];

   int n_tests = 0;
   int n_fail  = 0;
   int mem_lat = 1;
   bit stray_now = 1'b0;
   bit stray_gap = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_tests++;
      n_fail++;
      $display("FAIL %s: event not expected at t=%0t", name, $time);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Reference wrap: byte offset of the word within its line, advanced by 4 per beat, modulo line size.
   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i, input bit burst);
      logic [31:0] line_bytes;
      logic [31:0] base;
      logic [31:0] off;
      if (!burst) return start;
      line_bytes = 32'(LW * 4);
      base       = start & ~(line_bytes - 32'd1);
      off        = ((start & ~32'd3) + 32'(4 * i)) & (line_bytes - 32'd1);
      return base | off;
   endfunction

   task automatic push_exp(input bit is_ic, input bit rd_wr, input int beats,
                           input logic [31:0] addr0, input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] a;
      for (int b = 0; b < beats; b++) begin
         a = beat_addr(addr0, b, beats > 1);
         acc_q.push_back('{a, rd_wr, size, wdata});
         if (!rd_wr) rv_q.push_back('{is_ic, mem_word(a)});
      end
      dn_q.push_back('{is_ic, !rd_wr});
   endtask

   task automatic wait_done(input bit is_ic, input string name, output int cyc);
      bit got = 1'b0;
      cyc = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         cyc++;
         if (is_ic ? bus.ic_done : bus.dc_done) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) fail_now({name, "_done_timeout"});
   endtask

   task automatic check_drained(input string name);
      #1;
      check({name, "_acc_left"}, 32'(acc_q.size()), 32'd0);
      check({name, "_rv_left"}, 32'(rv_q.size()), 32'd0);
      check({name, "_done_left"}, 32'(dn_q.size()), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input string name, input bit chk_lat);
      bit got = 1'b0;
      int cyc;
      int exp_cyc;
      @(negedge clk);
      mem_lat = v.lat;
      if (v.is_ic) begin
         bus.ic_req  = 1'b1;
         bus.ic_addr = v.addr;
      end else begin
         bus.dc_req     = 1'b1;
         bus.dc_rd_wr   = v.rd_wr;
         bus.dc_burst   = v.burst;
         bus.dc_wr_size = v.wr_size;
         bus.dc_addr    = v.addr;
         bus.dc_wdata   = v.wdata;
      end
      #1;
      for (int i = 0; i < 50; i++) begin
         if (v.is_ic ? bus.ic_ack : bus.dc_ack) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
         #1;
      end
      check({name, "_ack"}, 32'(got), 32'd1);
      push_exp(v.is_ic, v.rd_wr, v.exp_beats, v.exp_addr0, v.exp_size, v.wdata);
      @(posedge clk);
      #1;
      bus.ic_req  = 1'b0;
      bus.dc_req  = 1'b0;
      bus.ic_addr = 32'hFFFF_FFFF;
      bus.dc_addr = 32'hFFFF_FFFF;
      bus.dc_wdata = 32'h0;
      wait_done(v.is_ic, name, cyc);
      exp_cyc = (v.exp_beats > 1) ? v.exp_beats * (v.lat + 1) : v.lat + 1;
      if (chk_lat) check({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
      check_drained(name);
   endtask

   // Memory model: ready pulses mem_lat cycles into each access; optional stray pulses.
   initial begin
      int cnt = 0;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            cnt = 0;
            bus.mem_ready = 1'b0;
         end else if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
            cnt = 0;
         end else if (stray_now) begin
            stray_now     = 1'b0;
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'hDEAD_BEEF;
         end else if (stray_gap && bus.ic_rvalid && !bus.ic_done && !bus.mem_en) begin
            bus.mem_ready = 1'b1;
            bus.mem_rdata = 32'hDEAD_BEEF;
         end else if (bus.mem_en) begin
            cnt++;
            if (cnt >= mem_lat) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = mem_word(bus.mem_addr);
            end
         end
      end
   end

   // Monitor: every access, returned word and completion is matched against the scoreboard.
   initial begin
      acc_t cur = '0;
      rv_t  r;
      dn_t  d;
      logic prev_en = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_en = 1'b0;
         end else begin
            if (bus.mem_en && !prev_en) begin
               if (acc_q.size() == 0) fail_now("unexpected_access");
               else begin
                  cur = acc_q.pop_front();
                  check("mem_addr", bus.mem_addr, cur.addr);
                  check("mem_rd_wr", 32'(bus.mem_rd_wr), 32'(cur.rd_wr));
                  check("mem_wr_size", 32'(bus.mem_wr_size), 32'(cur.size));
                  check("mem_wdata_oe", 32'(bus.mem_wdata_oe), 32'(cur.rd_wr));
                  if (cur.rd_wr) check("mem_wdata", bus.mem_wdata, cur.wdata);
               end
            end else if (bus.mem_en) begin
               check("mem_stable", 32'(bus.mem_addr == cur.addr && bus.mem_rd_wr == cur.rd_wr &&
                     bus.mem_wr_size == cur.size && bus.mem_wdata_oe == cur.rd_wr), 32'd1);
            end else if (bus.mem_wdata_oe) begin
               fail_now("oe_outside_access");
            end
            if (bus.ic_rvalid || bus.dc_rvalid) begin
               if (rv_q.size() == 0 || (bus.ic_rvalid && bus.dc_rvalid)) fail_now("unexpected_rvalid");
               else begin
                  r = rv_q.pop_front();
                  check("rvalid_owner", 32'(bus.ic_rvalid), 32'(r.is_ic));
                  check("rdata", bus.ic_rvalid ? bus.ic_rdata : bus.dc_rdata, r.data);
               end
            end
            if (bus.ic_done || bus.dc_done) begin
               if (dn_q.size() == 0 || (bus.ic_done && bus.dc_done)) fail_now("unexpected_done");
               else begin
                  d = dn_q.pop_front();
                  check("done_owner", 32'(bus.ic_done), 32'(d.is_ic));
                  check("done_rvalid", 32'(bus.ic_done ? bus.ic_rvalid : bus.dc_rvalid), 32'(d.rv));
               end
            end
            prev_en = bus.mem_en;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   cyc;
      bit   found;

      //           ic    rd_wr burst size  addr           wdata          lat beats addr0          size
      vecs[0] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_1238, 32'h0,         3,  4,    32'h0000_1238, 2'd0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h0000_0101, 32'h0000_00AB, 2,  1,    32'h0000_0101, 2'd1};
      vecs[2] = '{1'b0, 1'b0, 1'b0, 2'd0, 32'h0000_0046, 32'h0,         1,  1,    32'h0000_0046, 2'd0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 2'd2, 32'h0000_2004, 32'h0,         1,  4,    32'h0000_2004, 2'd0};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0000_0302, 32'h1234_5678, 2,  1,    32'h0000_0302, 2'd2};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_400F, 32'h0,         1,  4,    32'h0000_400C, 2'd0};
      vecs[6] = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h0000_100E, 32'h0,         2,  4,    32'h0000_100C, 2'd0};

      bus.ic_req = 1'b1; bus.ic_addr = '0;
      bus.dc_req = 1'b1; bus.dc_rd_wr = 1'b0; bus.dc_burst = 1'b0;
      bus.dc_wr_size = 2'd0; bus.dc_addr = '0; bus.dc_wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("rst_ic_ack", 32'(bus.ic_ack), 32'd0);
      check("rst_dc_ack", 32'(bus.dc_ack), 32'd0);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check("rst_mem_attr", {bus.mem_addr[29:0], bus.mem_wr_size} | 32'(bus.mem_rd_wr), 32'd0);
      check("rst_mem_wdata", bus.mem_wdata | 32'(bus.mem_wdata_oe), 32'd0);
      check("rst_pulses", 32'({bus.ic_rvalid, bus.ic_done, bus.dc_rvalid, bus.dc_done}), 32'd0);
      check("rst_rdata", bus.ic_rdata | bus.dc_rdata, 32'd0);
      bus.ic_req = 1'b0;
      bus.dc_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;

      // Tie right after reset: DC first, IC in the IDLE cycle after dc_done, then DC wins the next tie.
      @(negedge clk);
      mem_lat = 2;
      bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1238;
      bus.dc_req = 1'b1; bus.dc_rd_wr = 1'b0; bus.dc_burst = 1'b0; bus.dc_addr = 32'h0000_0080;
      #1;
      check("tie1_dc_ack", 32'(bus.dc_ack), 32'd1);
      check("tie1_ic_ack", 32'(bus.ic_ack), 32'd0);
      push_exp(1'b0, 1'b0, 1, 32'h0000_0080, 2'd0, 32'h0);
      @(posedge clk); #1;
      bus.dc_req = 1'b0;
      wait_done(1'b0, "tie1_dc", cyc);
      check("tie1_ic_waits", 32'(bus.ic_ack), 32'd0);
      @(negedge clk); #1;
      check("tie1_ic_ack_after", 32'(bus.ic_ack), 32'd1);
      push_exp(1'b1, 1'b0, LW, 32'h0000_1238, 2'd0, 32'h0);
      @(posedge clk); #1;
      bus.ic_req = 1'b0;
      wait_done(1'b1, "tie1_ic", cyc);
      @(negedge clk);
      bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_0500;
      bus.dc_req = 1'b1; bus.dc_rd_wr = 1'b1; bus.dc_wr_size = 2'd0;
      bus.dc_addr = 32'h0000_0200; bus.dc_wdata = 32'h0000_0055;
      #1;
      check("tie2_dc_ack", 32'(bus.dc_ack), 32'd1);
      check("tie2_ic_ack", 32'(bus.ic_ack), 32'd0);
      push_exp(1'b0, 1'b1, 1, 32'h0000_0200, 2'd0, 32'h0000_0055);
      @(posedge clk); #1;
      bus.dc_req = 1'b0;
      wait_done(1'b0, "tie2_dc", cyc);
      @(negedge clk); #1;
      check("tie2_ic_ack_after", 32'(bus.ic_ack), 32'd1);
      push_exp(1'b1, 1'b0, LW, 32'h0000_0500, 2'd0, 32'h0);
      @(posedge clk); #1;
      bus.ic_req = 1'b0;
      wait_done(1'b1, "tie2_ic", cyc);
      check_drained("tie");

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);

      // Stray ready while idle: nothing may happen.
      @(negedge clk);
      stray_now = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("stray_idle_mem_en", 32'(bus.mem_en), 32'd0);
      check("stray_idle_pulses", 32'({bus.ic_rvalid, bus.ic_done, bus.dc_rvalid, bus.dc_done}), 32'd0);
      run_vec(vecs[2], "after_stray_idle", 1'b1);

      // Stray ready during each GAP of an I-side fill.
      stray_gap = 1'b1;
      run_vec(vecs[0], "stray_gap", 1'b0);
      stray_gap = 1'b0;

      // Reset during beat 2 of an I-side fill.
      @(negedge clk);
      mem_lat = 3;
      bus.ic_req = 1'b1; bus.ic_addr = 32'h0000_1238;
      #1;
      check("rstmid_ack", 32'(bus.ic_ack), 32'd1);
      push_exp(1'b1, 1'b0, LW, 32'h0000_1238, 2'd0, 32'h0);
      @(posedge clk); #1;
      bus.ic_req = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.mem_en && bus.mem_addr == 32'h0000_123C) begin
            found = 1'b1;
            break;
         end
      end
      check("rstmid_reach_beat2", 32'(found), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("rstmid_mem_en_async", 32'(bus.mem_en), 32'd0);
      check("rstmid_no_done", 32'({bus.ic_done, bus.ic_rvalid}), 32'd0);
      acc_q.delete();
      rv_q.delete();
      dn_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      check("rstmid_idle_mem_en", 32'(bus.mem_en), 32'd0);
      run_vec(vecs[2], "after_reset", 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/main_memory_arbiter.md
# main_memory_arbiter

Sequencer and arbiter sitting in front of `main_memory_top`, sharing its single en/rd_wr/ready port between the instruction-cache fill path and the data-cache path. It grants one requester at a time (round-robin on conflict) and drives the memory handshake. It breaks a line fill into `LINE_WORDS` back-to-back word reads in critical-word-first wrap order, and returns each word and a completion pulse to the owner.

## Interface

Parameters:
- `LINE_WORDS`, default 4: words per line fill; power of two, 2..16.

Ports:
- `clk` in 1: clock, all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `ic_req` in 1: I-side request, always a `LINE_WORDS` burst read. Held until `ic_ack`.
- `ic_addr` in 32: I-side byte address of the critical word.
- `ic_ack` out 1: request accepted. Combinational, one-cycle pulse.
- `ic_rvalid` out 1: `ic_rdata` valid this cycle (one pulse per beat).
- `ic_rdata` out 32: returned word.
- `ic_done` out 1: last beat / transaction complete pulse.
- `dc_req` in 1: D-side request, held until `dc_ack`.
- `dc_rd_wr` in 1: 1 = write, 0 = read.
- `dc_burst` in 1: read only. 1 = `LINE_WORDS` burst, 0 = single word. Ignored on writes.
- `dc_wr_size` in 2: 0 = 32-bit, 1 = byte, 2 = 16-bit. Passed through to memory.
- `dc_addr` in 32: byte address.
- `dc_wdata` in 32: write data.
- `dc_ack`, `dc_rvalid`, `dc_rdata`, `dc_done`: as the I-side equivalents.
- `mem_en` out 1: to memory `en`.
- `mem_rd_wr` out 1: to memory `rd_wr`.
- `mem_wr_size` out 2: to memory `wr_size`.
- `mem_addr` out 32: to memory `addr`.
- `mem_wdata` out 32: write data for the external tristate onto memory `data`.
- `mem_wdata_oe` out 1: enable for that tristate.
- `mem_rdata` in 32: memory `data` bus as observed.
- `mem_ready` in 1: memory `ready`, one-cycle pulse per access.

## Operation

States: IDLE, ACCESS, GAP, DONE.

- **IDLE**
  - Arbitration:
    - If exactly one request is high, that requester wins.
    - If both are high, the requester not named in `last_grant` wins.
    - `last_grant` resets to IC, so the first tie goes to DC.
  - Assert the winner's `ack` in the same cycle.
  - On the edge:
    - Latch owner, addr, rd_wr, wr_size and wdata.
    - Set `nbeats` = `LINE_WORDS` for any burst, else 1.
    - Clear the beat counter to 0.
    - Go to ACCESS.
- **ACCESS**
  - `mem_en` = 1.
  - `mem_rd_wr`, `mem_wr_size` and `mem_addr` come from the latched values.
  - `mem_wdata_oe` = 1 only for writes.
  - Stay here until `mem_ready`. On `mem_ready`:
    - Capture `mem_rdata` into the return register.
    - Increment the beat counter.
    - Go to GAP if beats remain, else DONE.
- **GAP**
  - `mem_en` = 0.
  - Owner's `rvalid` = 1 with the captured word.
  - Next edge: ACCESS.
- **DONE**
  - `mem_en` = 0.
  - Owner's `rvalid` = 1 (reads only) and `done` = 1.
  - `last_grant` is set to the owner.
  - Next edge: IDLE.

Address generation:
- Single access: `mem_addr` = latched addr unchanged.
- Burst: `mem_addr[1:0]` = 0.
  - Index bits [2+log2(`LINE_WORDS`)-1:2] = (start index + beat) mod `LINE_WORDS`.
  - Upper bits held constant. The burst wraps inside the line and never crosses it.
- Burst `mem_wr_size` is forced to 0.

## Timing

- Reset values:
  - State IDLE, `last_grant` = IC.
  - All outputs 0: `mem_en`, `mem_rd_wr`, `mem_wr_size`, `mem_addr`, `mem_wdata`, `mem_wdata_oe`, all `ack`/`rvalid`/`done`, and both `rdata`.
- Reset mid-transaction: abort immediately, `mem_en` drops asynchronously, and no `done` is issued.
- `ack` is valid only in IDLE. Requester fields need only be stable in the `ack` cycle.
  - A request deasserted after `ack` does not cancel the transaction.
- `mem_en` and all mem-side attributes are stable for the whole ACCESS stay.
- `mem_en` is low for at least one cycle between beats and between transactions.
- Per beat: `rvalid` occurs exactly 1 cycle after the `mem_ready` cycle.
- Single read or write: `done` occurs 1 cycle after `mem_ready`.
- Back-to-back turnaround: the next grant can occur at the earliest in the cycle after DONE.
- Minimum total latency:
  - Single access = 1 (ack) + k (memory) + 1.
  - Burst = `LINE_WORDS`·(k+1) + 1.
- `mem_ready` outside ACCESS is ignored.
- A request from the non-owner during a transaction waits and is granted in the IDLE cycle after DONE. This guarantees no starvation.
- The non-owner's `rvalid`/`done` are never asserted.

## Test plan

- **I-side burst fill:** reset; `ic_req`, `ic_addr`=0x0000_1238, memory ready 3 cycles after each `mem_en` rise -> `mem_addr` sequence 0x1238, 0x123C, 0x1230, 0x1234; 4 `ic_rvalid` pulses carrying the matching data; `ic_done` coincides with the 4th `rvalid`; `mem_en` is low one cycle between beats.
- **D-side byte write:** `dc_rd_wr`=1, `dc_wr_size`=1, `dc_addr`=0x0000_0101, `dc_wdata`=0xAB -> `mem_wdata_oe`=1 with `mem_wr_size`=1 and `mem_addr`=0x101 through ACCESS; `dc_done` 1 cycle after `mem_ready`; no `dc_rvalid`.
- **Simultaneous requests:** `ic_req` and `dc_req` rise together after reset -> `dc_ack` first; `ic_ack` in the IDLE cycle after `dc_done`. Then a second tie -> DC wins again, since `last_grant`=IC after the I-side completes.
- **Single D-side read:** `dc_burst`=0, addr 0x0000_0046 -> one access with `mem_addr`=0x46 unchanged; `dc_rvalid` and `dc_done` in the same cycle with `dc_rdata`=`mem_rdata`.
- **Reset mid-burst:** assert `reset` during beat 2 of an I-side fill -> `mem_en` drops in the same cycle; no `ic_done`; a new `dc_req` after reset is granted normally.
- **Stray ready:** pulse `mem_ready` while in IDLE and while in GAP -> no state change and no `rvalid`/`done`.
